// File: rtl/am_tx.sv
// Active-message transmitter: frames one command into a header beat, followed
// by its argument beats and payload beats, on a single AXI-Stream master port.
module am_tx #(
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 16,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ID_WIDTH-1:0]   cmd_src,
    input  logic [ID_WIDTH-1:0]   cmd_dst,
    input  logic [7:0]            cmd_type,
    input  logic [3:0]            cmd_handler,
    input  logic [2:0]            cmd_arg_count,
    input  logic [LEN_WIDTH-1:0]  cmd_payload_len,
    input  logic [DATA_WIDTH-1:0] arg_tdata,
    input  logic                  arg_tvalid,
    output logic                  arg_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tdest,
    output logic                  busy,
    output logic                  err_len,
    output logic [31:0]           pkt_count
);

    typedef enum logic [1:0] {IDLE, HEADER, ARGS, PAYLOAD} state_t;

    state_t                 state, stateNext;
    logic [ID_WIDTH-1:0]    srcReg, dstReg;
    logic [7:0]             typeReg;
    logic [3:0]             handlerReg;
    logic [2:0]             argCountReg, argCnt;
    logic [LEN_WIDTH-1:0]   lenReg, lenCnt;
    logic [DATA_WIDTH-1:0]  hdrWord;
    logic [31:0]            pktCount;
    logic                   errLen;
    logic                   mBeat;

    assign busy         = (state != IDLE);
    assign m_axis_tdest = dstReg;
    assign pkt_count    = pktCount;
    assign err_len      = errLen;
    assign mBeat        = m_axis_tvalid && m_axis_tready;

    // Header word assembled from latched command fields, zero-extended.
    always_comb begin
        hdrWord                   = '0;
        hdrWord[ID_WIDTH-1:0]     = srcReg;
        hdrWord[16 +: ID_WIDTH]   = dstReg;
        hdrWord[32 +: LEN_WIDTH]  = lenReg;
        hdrWord[47:44]            = handlerReg;
        hdrWord[50:48]            = argCountReg;
        hdrWord[63:56]            = typeReg;
    end

    // Next-state and stream muxing; args/payload are combinational pass-through.
    always_comb begin
        stateNext     = state;
        cmd_ready     = 1'b0;
        arg_tready    = 1'b0;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) stateNext = HEADER;
            end
            HEADER: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdrWord;
                m_axis_tlast  = (argCountReg == 3'd0) && (lenReg == '0);
                if (m_axis_tready) begin
                    if (argCountReg != 3'd0)  stateNext = ARGS;
                    else if (lenReg != '0)    stateNext = PAYLOAD;
                    else                      stateNext = IDLE;
                end
            end
            ARGS: begin
                m_axis_tvalid = arg_tvalid;
                m_axis_tdata  = arg_tdata;
                arg_tready    = m_axis_tready;
                m_axis_tlast  = (argCnt == 3'd1) && (lenCnt == '0);
                if (arg_tvalid && m_axis_tready && argCnt == 3'd1)
                    stateNext = (lenCnt != '0) ? PAYLOAD : IDLE;
            end
            PAYLOAD: begin
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tdata  = s_axis_tdata;
                s_axis_tready = m_axis_tready;
                m_axis_tlast  = (lenCnt == LEN_WIDTH'(1));
                if (s_axis_tvalid && m_axis_tready && lenCnt == LEN_WIDTH'(1))
                    stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // State, latched command, beat counters, packet counter and length-error pulse.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state       <= IDLE;
            srcReg      <= '0;
            dstReg      <= '0;
            typeReg     <= '0;
            handlerReg  <= '0;
            argCountReg <= '0;
            lenReg      <= '0;
            argCnt      <= '0;
            lenCnt      <= '0;
            pktCount    <= '0;
            errLen      <= 1'b0;
        end else begin
            state  <= stateNext;
            // Framing follows lenCnt; input TLAST is only checked against it.
            errLen <= (state == PAYLOAD) && s_axis_tvalid && m_axis_tready &&
                      (s_axis_tlast != (lenCnt == LEN_WIDTH'(1)));
            if (state == IDLE && cmd_valid) begin
                srcReg      <= cmd_src;
                dstReg      <= cmd_dst;
                typeReg     <= cmd_type;
                handlerReg  <= cmd_handler;
                argCountReg <= cmd_arg_count;
                lenReg      <= cmd_payload_len;
                argCnt      <= cmd_arg_count;
                lenCnt      <= cmd_payload_len;
            end
            if (state == ARGS && mBeat)    argCnt <= argCnt - 3'd1;
            if (state == PAYLOAD && mBeat) lenCnt <= lenCnt - LEN_WIDTH'(1);
            if (mBeat && m_axis_tlast)     pktCount <= pktCount + 32'd1;
        end
    end

endmodule

// File: tb/tb_am_tx.sv
// Randomized bench for am_tx: each packet's expected beat list is built from
// the header layout and framing rules, then compared against the stream output.
module tb_am_tx;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        cmd_valid, cmd_ready;
    logic [15:0] cmd_src, cmd_dst;
    logic [7:0]  cmd_type;
    logic [3:0]  cmd_handler;
    logic [2:0]  cmd_arg_count;
    logic [11:0] cmd_payload_len;
    logic [63:0] arg_tdata, s_axis_tdata, m_axis_tdata;
    logic        arg_tvalid, arg_tready;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [15:0] m_axis_tdest;
    logic        busy, err_len;
    logic [31:0] pkt_count;

    int cmpCnt = 0;
    int misCnt = 0;
    int cyc = 0;
    int errCnt = 0;
    int errExp = 0;
    int pktExp = 0;
    int lastHsCyc = 0;
    bit prevDone = 0;

    am_tx dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_type(cmd_type),
        .cmd_handler(cmd_handler), .cmd_arg_count(cmd_arg_count),
        .cmd_payload_len(cmd_payload_len),
        .arg_tdata(arg_tdata), .arg_tvalid(arg_tvalid), .arg_tready(arg_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tdest(m_axis_tdest), .busy(busy), .err_len(err_len),
        .pkt_count(pkt_count)
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc <= cyc + 1;

    always @(posedge ap_clk) begin
        #1;
        if (err_len) errCnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        cmpCnt++;
        if (got !== exp) begin
            misCnt++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One packet. dirData selects the fixed 0xA../0x10.. data pattern;
    // tlMask bit i drives s_axis_tlast on payload beat i; rstBeat>=0 asserts
    // reset while that payload beat is being offered.
    task automatic runPkt(input logic [15:0] src, input logic [15:0] dst,
                          input logic [7:0] typ, input logic [3:0] hnd,
                          input int na, input int len, input logic [31:0] tlMask,
                          input bit stall, input bit dirData, input int rstBeat);
        logic [63:0] argv[8];
        logic [63:0] pay[$];
        logic [63:0] expD[$];
        bit          expL[$];
        logic [63:0] hdr, prevData;
        logic [11:0] len12;
        logic [2:0]  na3;
        bit          cmdDone, done, argV, payV, prevStall, prevLast;
        int          aIdx, pIdx, got, cmdCyc, pktErr;

        len12 = 12'(len);
        na3   = 3'(na);
        for (int i = 0; i < 8; i++)
            argv[i] = dirData ? 64'(32'hA + i) : {$urandom, $urandom};
        for (int i = 0; i < len; i++)
            pay.push_back(dirData ? 64'(32'h10 + i) : {$urandom, $urandom});
        hdr = {typ, 5'b0, na3, hnd, len12, dst, src};
        expD.push_back(hdr);
        for (int i = 0; i < na; i++) expD.push_back(argv[i]);
        for (int i = 0; i < len; i++) expD.push_back(pay[i]);
        for (int i = 0; i < expD.size(); i++) expL.push_back(i == expD.size() - 1);
        pktErr = 0;
        for (int i = 0; i < len; i++)
            if ((i < 32 && tlMask[i]) != (i == len - 1)) pktErr++;

        cmdDone = 0; done = 0; argV = 0; payV = 0; prevStall = 0; prevLast = 0;
        prevData = '0; aIdx = 0; pIdx = 0; got = 0; cmdCyc = 0;

        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge ap_clk);
            if (rstBeat >= 0 && cmdDone && pIdx == rstBeat) begin
                ap_rst = 1'b1;
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = pay[pIdx];
                m_axis_tready = 1'b1;
                @(posedge ap_clk);
                #1;
                chk("rstTvalid", 64'(m_axis_tvalid), 64'd0);
                chk("rstBusy", 64'(busy), 64'd0);
                chk("rstPktCnt", 64'(pkt_count), 64'd0);
                chk("rstCmdRdy", 64'(cmd_ready), 64'd1);
                chk("rstTdest", 64'(m_axis_tdest), 64'd0);
                chk("rstTlast", 64'(m_axis_tlast), 64'd0);
                @(negedge ap_clk);
                ap_rst = 1'b0;
                s_axis_tvalid = 1'b0;
                arg_tvalid = 1'b0;
                pktExp = 0;
                prevDone = 0;
                return;
            end
            cmd_valid       = !cmdDone;
            cmd_src         = src;
            cmd_dst         = dst;
            cmd_type        = typ;
            cmd_handler     = hnd;
            cmd_arg_count   = na3;
            cmd_payload_len = len12;
            m_axis_tready   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!argV) argV = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!payV) payV = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            arg_tvalid    = argV && (aIdx < na);
            arg_tdata     = argv[aIdx & 7];
            s_axis_tvalid = payV && (pIdx < len);
            s_axis_tdata  = (pIdx < len) ? pay[pIdx] : 64'd0;
            s_axis_tlast  = (pIdx < len && pIdx < 32) ? tlMask[pIdx] : 1'b0;
            #1;
            if (c == 0) begin
                chk("idleBusy", 64'(busy), 64'd0);
                chk("idleCmdRdy", 64'(cmd_ready), 64'd1);
                chk("errLenCnt", 64'(errCnt), 64'(errExp));
                chk("pktCnt", 64'(pkt_count), 64'(pktExp));
            end
            if (cmdDone) begin
                chk("busy", 64'(busy), 64'd1);
                if (cyc == cmdCyc + 1) chk("hdrLatency", 64'(m_axis_tvalid), 64'd1);
            end
            if (prevStall) begin
                chk("stallValid", 64'(m_axis_tvalid), 64'd1);
                chk("stallData", m_axis_tdata, prevData);
                chk("stallLast", 64'(m_axis_tlast), 64'(prevLast));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (got < expD.size()) begin
                    chk("beatData", m_axis_tdata, expD[got]);
                    chk("beatLast", 64'(m_axis_tlast), 64'(expL[got]));
                    chk("beatDest", 64'(m_axis_tdest), 64'(dst));
                end else begin
                    chk("extraBeat", 64'(got), 64'(expD.size() - 1));
                end
                got++;
                if (m_axis_tlast) begin
                    done = 1;
                    lastHsCyc = cyc;
                end
            end
            prevStall = m_axis_tvalid && !m_axis_tready;
            prevData  = m_axis_tdata;
            prevLast  = m_axis_tlast;
            if (cmd_valid && cmd_ready) begin
                if (prevDone) chk("b2bGap", 64'(cyc - lastHsCyc + 1), 64'd2);
                cmdDone = 1;
                cmdCyc  = cyc;
            end
            if (arg_tvalid && arg_tready) begin aIdx++; argV = 0; end
            if (s_axis_tvalid && s_axis_tready) begin pIdx++; payV = 0; end
        end
        if (!done) chk("timeout", 64'd0, 64'd1);
        chk("beatCount", 64'(got), 64'(expD.size()));
        errExp += pktErr;
        pktExp++;
        prevDone = done;
    endtask

    initial begin
        int na, len;
        logic [31:0] m;
        ap_rst = 1'b1;
        cmd_valid = 0; cmd_src = 0; cmd_dst = 0; cmd_type = 0; cmd_handler = 0;
        cmd_arg_count = 0; cmd_payload_len = 0;
        arg_tdata = 0; arg_tvalid = 0; s_axis_tdata = 0; s_axis_tvalid = 0;
        s_axis_tlast = 0; m_axis_tready = 0;
        repeat (3) @(posedge ap_clk);
        #1;
        chk("rCmdRdy", 64'(cmd_ready), 64'd1);
        chk("rTvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rTlast", 64'(m_axis_tlast), 64'd0);
        chk("rTdata", m_axis_tdata, 64'd0);
        chk("rTdest", 64'(m_axis_tdest), 64'd0);
        chk("rArgRdy", 64'(arg_tready), 64'd0);
        chk("rSRdy", 64'(s_axis_tready), 64'd0);
        chk("rBusy", 64'(busy), 64'd0);
        chk("rErr", 64'(err_len), 64'd0);
        chk("rPktCnt", 64'(pkt_count), 64'd0);
        @(negedge ap_clk);
        ap_rst = 1'b0;

        runPkt(16'h0001, 16'h0002, 8'h01, 4'd3, 0, 0, 32'h0, 0, 1, -1);
        runPkt(16'h1234, 16'hBEEF, 8'h22, 4'd5, 2, 3, 32'h4, 0, 1, -1);
        runPkt(16'h1234, 16'hBEEF, 8'h22, 4'd5, 2, 3, 32'h4, 1, 1, -1);
        // Early TLAST on beat 2 (TLAST also on beat 4): one error pulse.
        runPkt(16'h0a0a, 16'h0b0b, 8'h03, 4'd1, 0, 4, 32'ha, 0, 1, -1);
        // Missing TLAST on final beat: one error pulse.
        runPkt(16'h0c0c, 16'h0d0d, 8'h04, 4'd2, 0, 2, 32'h0, 0, 1, -1);
        // Reset while the third of five payload beats is offered.
        runPkt(16'h0e0e, 16'h0f0f, 8'h05, 4'd7, 1, 5, 32'h10, 0, 1, 2);
        runPkt(16'h0101, 16'h0202, 8'h06, 4'd8, 1, 2, 32'h2, 0, 1, -1);

        for (int k = 0; k < 40; k++) begin
            na  = $urandom_range(0, 7);
            len = $urandom_range(0, 12);
            m   = (len > 0) ? (32'h1 << (len - 1)) : 32'h0;
            if ($urandom_range(0, 3) == 0) m = $urandom & 32'h1fff;
            runPkt(16'($urandom), 16'($urandom), 8'($urandom), 4'($urandom),
                   na, len, m, 1, 0, -1);
        end

        // Let the final error pulse and counter settle, then check totals.
        @(negedge ap_clk);
        cmd_valid = 0; arg_tvalid = 0; s_axis_tvalid = 0;
        repeat (3) @(negedge ap_clk);
        chk("finalErrLen", 64'(errCnt), 64'(errExp));
        chk("finalPktCnt", 64'(pkt_count), 64'(pktExp));
        chk("finalBusy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, misCnt);
        $finish;
    end

endmodule
